// File: rtl/seq_detector_param_if.sv
// Bundle of stream, configuration and result signals for seq_detector_param.
// The master side drives stream/config and observes results; the slave side is the detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               x;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               z;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  z, match_count
  );

  modport slave (
    input  en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output z, match_count
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (up to MAX_LEN bits) with
// selectable overlap mode and a saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_0101,
  parameter int                 DEF_LEN     = 3,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  seq_detector_param_if.slave bus
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_reg, pattern_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic               overlap_reg, overlap_next;
  logic [MAX_LEN-1:0] history_reg, history_next;
  logic [LEN_W-1:0]   fill_reg, fill_next;
  logic               z_reg, z_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic [MAX_LEN-1:0] history_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;

  // Only the low len bits of history take part in the comparison.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (len_reg > LEN_W'(gi));
  end

  assign history_shift = {history_reg[MAX_LEN-2:0], bus.x};
  assign fill_inc      = (fill_reg == LEN_MAX) ? fill_reg : fill_reg + 1'b1;

  // A load cycle discards the incoming sample, so it can never complete a match.
  assign match = bus.en && !bus.cfg_load && (len_reg != '0) &&
                 (fill_inc >= len_reg) &&
                 (((history_shift ^ pattern_reg) & len_mask) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_reg <= DEF_PATTERN;
      len_reg     <= LEN_W'(DEF_LEN);
      overlap_reg <= DEF_OVERLAP;
      history_reg <= '0;
      fill_reg    <= '0;
      z_reg       <= 1'b0;
      count_reg   <= '0;
    end else begin
      pattern_reg <= pattern_next;
      len_reg     <= len_next;
      overlap_reg <= overlap_next;
      history_reg <= history_next;
      fill_reg    <= fill_next;
      z_reg       <= z_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    pattern_next = pattern_reg;
    len_next     = len_reg;
    overlap_next = overlap_reg;
    history_next = history_reg;
    fill_next    = fill_reg;
    z_next       = 1'b0;
    count_next   = count_reg;

    if (bus.cfg_load) begin
      pattern_next = bus.cfg_pattern;
      len_next     = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;
      overlap_next = bus.cfg_overlap;
      history_next = '0;
      fill_next    = '0;
    end else if (bus.en) begin
      history_next = history_shift;
      fill_next    = (match && !overlap_reg) ? '0 : fill_inc;
      z_next       = match;
    end

    // Clear takes effect before a same-cycle increment.
    if (bus.cnt_clr) begin
      count_next = match ? CNT_W'(1) : '0;
    end else if (match && count_reg != CNT_MAX) begin
      count_next = count_reg + 1'b1;
    end
  end

  assign bus.z           = z_reg;
  assign bus.match_count = count_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed and randomized bench for seq_detector_param against a queue-based
// reference model of the detection rules.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic clk;
  logic rst;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .DEF_PATTERN(8'b0000_0101), .DEF_LEN(3), .DEF_OVERLAP(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: received bits kept oldest-first in a queue, plus a count
  // of samples received since the last reset/load/non-overlap match.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_q[$];
  int         m_fresh;
  logic       exp_z;
  logic [7:0] exp_cnt;

  task automatic model_reset();
    m_pat   = 8'b0000_0101;
    m_len   = 3;
    m_ovl   = 1'b1;
    m_q.delete();
    m_fresh = 0;
    exp_z   = 1'b0;
    exp_cnt = 8'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one clock of inputs, advance the model, then compare both outputs.
  task automatic cycle(input bit en_i, input bit x_i, input bit load_i,
                       input logic [7:0] pat_i, input int len_i, input bit ovl_i,
                       input bit clr_i, input string tag);
    bit m;
    m = 1'b0;
    bus.en          = en_i;
    bus.x           = x_i;
    bus.cfg_load    = load_i;
    bus.cfg_pattern = pat_i;
    bus.cfg_len     = LEN_W'(len_i);
    bus.cfg_overlap = ovl_i;
    bus.cnt_clr     = clr_i;

    if (load_i) begin
      m_pat   = pat_i;
      m_len   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
      m_ovl   = ovl_i;
      m_q.delete();
      m_fresh = 0;
    end else if (en_i) begin
      m_q.push_back(x_i);
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      if (m_fresh < MAX_LEN) m_fresh++;
      if (m_len > 0 && m_fresh >= m_len) begin
        m = 1'b1;
        // Newest bit must equal pattern[0], oldest of the window pattern[len-1].
        for (int i = 0; i < m_len; i++)
          if (m_q[m_q.size() - 1 - i] != m_pat[i]) m = 1'b0;
      end
      if (m && !m_ovl) m_fresh = 0;
    end
    exp_z = m;
    if (clr_i) exp_cnt = m ? 8'd1 : 8'd0;
    else if (m && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;

    @(posedge clk);
    #1;
    check({tag, ".z"}, 32'(bus.z), 32'(exp_z));
    check({tag, ".cnt"}, 32'(bus.match_count), 32'(exp_cnt));
  endtask

  task automatic samp(input bit x_i, input string tag);
    cycle(1'b1, x_i, 1'b0, 8'h00, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input logic [7:0] p, input int l, input bit o, input string tag);
    cycle(1'b0, 1'b0, 1'b1, p, l, o, 1'b0, tag);
  endtask

  task automatic clear(input string tag);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    bit seq5[5];
    seq5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    bus.en = 1'b0; bus.x = 1'b0; bus.cfg_load = 1'b0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cnt_clr = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("reset.z", 32'(bus.z), 32'd0);
    check("reset.cnt", 32'(bus.match_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: default 101 with overlap
    for (int i = 0; i < 5; i++) samp(seq5[i], "t1");
    check("t1.total", 32'(bus.match_count), 32'd2);

    // 2: non-overlapping 101
    clear("t2.clr");
    load(8'b101, 3, 1'b0, "t2.load");
    for (int i = 0; i < 5; i++) samp(seq5[i], "t2");
    check("t2.total", 32'(bus.match_count), 32'd1);
    samp(1'b1, "t2b"); samp(1'b0, "t2b"); samp(1'b1, "t2b");
    check("t2b.z", 32'(bus.z), 32'd1);

    // 3: 1101 with an en gap before the last bit
    load(8'b1101, 4, 1'b1, "t3.load");
    samp(1'b1, "t3"); samp(1'b1, "t3"); samp(1'b0, "t3");
    idle("t3.gap"); idle("t3.gap");
    samp(1'b1, "t3");
    check("t3.z", 32'(bus.z), 32'd1);

    // 4: load mid-pattern abandons the partial match; x during load is dropped
    load(8'b101, 3, 1'b1, "t4.load");
    samp(1'b1, "t4"); samp(1'b0, "t4");
    cycle(1'b1, 1'b1, 1'b1, 8'b101, 3, 1'b1, 1'b0, "t4.reload");
    samp(1'b1, "t4");
    check("t4.nomatch", 32'(bus.z), 32'd0);
    samp(1'b1, "t4"); samp(1'b0, "t4"); samp(1'b1, "t4");
    check("t4.match", 32'(bus.z), 32'd1);

    // len clamp and len=0
    load(8'hFF, 15, 1'b1, "clamp.load");
    for (int i = 0; i < 9; i++) samp(1'b1, "clamp");
    load(8'h00, 0, 1'b1, "len0.load");
    for (int i = 0; i < 6; i++) samp(1'b0, "len0");

    // 5: saturation and clear-with-match
    load(8'b11, 2, 1'b1, "t5.load");
    clear("t5.clr");
    for (int i = 0; i < 262; i++) samp(1'b1, "t5");
    check("t5.sat", 32'(bus.match_count), 32'd255);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, "t5.clrmatch");
    check("t5.clrmatch1", 32'(bus.match_count), 32'd1);

    // Randomized phases
    for (int ph = 0; ph < 12; ph++) begin
      int l;
      l = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 10));
      load(8'($urandom), l, 1'($urandom), "rnd.load");
      for (int c = 0; c < 60; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)
          cycle(1'($urandom), 1'($urandom), 1'b1, 8'($urandom),
                int'($urandom_range(1, 4)), 1'($urandom), 1'b0, "rnd.reload");
        else
          cycle(r < 88, 1'($urandom), 1'b0, 8'h00, 0, 1'b0, r > 96, "rnd");
      end
    end

    // 6: asynchronous reset mid-cycle
    load(8'b101, 3, 1'b1, "t6.load");
    samp(1'b1, "t6"); samp(1'b1, "t6"); samp(1'b0, "t6"); samp(1'b1, "t6");
    samp(1'b1, "t6"); samp(1'b0, "t6");
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("t6.async.z", 32'(bus.z), 32'd0);
    check("t6.async.cnt", 32'(bus.match_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    samp(1'b1, "t6.after");
    check("t6.nomatch", 32'(bus.z), 32'd0);
    samp(1'b0, "t6.after"); samp(1'b1, "t6.after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector, successor to the fixed-pattern "101" Moore detector. It watches a 1-bit serial stream and detects a pattern that is programmable at runtime, up to MAX_LEN bits long. Overlapping or non-overlapping detection is selectable, and a saturating match counter is kept. It sits between a serial input front end and control logic that consumes match pulses or counts.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match_count
DEF_PATTERN, 8'b0000_0101, pattern in effect after reset (MAX_LEN bits, LSB-aligned)
DEF_LEN, 3, pattern length in effect after reset
DEF_OVERLAP, 1, overlap mode in effect after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample qualifier; x is consumed only when en=1
x  input  1  serial data bit
cfg_load  input  1  one-cycle strobe; latches cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  MAX_LEN  new pattern, LSB-aligned
cfg_len  input  LEN_W  new pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_count
z  output  1  registered match flag
match_count  output  CNT_W  saturating count of matches

Behaviour:
- Reset (rst=1, async): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, history=0, fill=0, z=0, match_count=0. All outputs stay 0 while rst is held.
- Bit order: pattern[len-1] is the first bit received, pattern[0] is the last. A new sample x shifts into history[0]; older bits move toward the MSB.
- fill is a saturating count (0..MAX_LEN) of valid bits in history since the last reset, load, or non-overlap match.
- Match condition, evaluated on the incoming sample when en=1: fill_next >= len, and history_next[len-1:0] == pattern[len-1:0].
- z is registered. It goes to 1 in the cycle after the completing sample and lasts exactly one cycle per match. If en=1 and a match occurs on consecutive samples, z stays 1 on consecutive cycles.
- If en=0: history, fill and match logic hold, and z=0 the next cycle.
- Overlap=1: on a match, history and fill are kept, so the matching bits can start the next match.
- Overlap=0: on a match, fill is cleared to 0. The next match needs len fresh samples.
- len=0 disables detection: z stays 0 and history still shifts.
- cfg_len > MAX_LEN is clamped to MAX_LEN when latched.
- cfg_load=1 (highest priority after rst):
  - latches the new config and clears history and fill;
  - z=0 next cycle;
  - x is ignored that cycle even if en=1;
  - match_count is not affected.
- match_count increments by 1 per match and saturates at 2^CNT_W-1.
- cnt_clr=1 sets match_count to 0. If cnt_clr and a match occur in the same cycle, the result is 1 (the clear applies first, then the increment).
- Reset mid-stream aborts any partial match immediately. The first sample after rst deasserts starts with fill=0.
- Latency: from the completing sample to z=1 is 1 cycle; from the completing sample to the match_count update is 1 cycle.

Test Plan:
1. Defaults (101, overlap), en=1, x=1,0,1,0,1 on cycles 0-4 -> z=1 on cycles 3 and 5 only; match_count=2.
2. cfg_load pattern 101, len=3, overlap=0; x=1,0,1,0,1 -> single z pulse on cycle 3; match_count=1. Then x=1,0,1 -> second pulse.
3. Load 1101, len=4. Stream 1,1,0,1 with en dropped for 2 cycles between bit 2 and bit 3 -> z=1 one cycle after the final bit; no pulse during the en=0 gap.
4. Partial stream 1,0, then cfg_load (same 101), then x=1 -> no match; fresh 1,0,1 -> match.
5. CNT_W=2 build, 5 matches -> match_count saturates at 3. cnt_clr asserted in the same cycle as a match -> match_count=1.
6. Assert rst asynchronously (mid-cycle) after 1,0 -> z=0 and match_count=0 immediately. Defaults restored; x=1 alone yields no match.
